alion_mem_arbiter: RTL and testbench

- Two-master round-robin arbiter sharing the alion core's single native memory port (valid/ready, instr flag, addr, wdata, wstrb, rdata).
- m0 is normally instruction fetch; m1 is normally data or debug/DMA.
- Latches the granted request and drives the shared port.
- Routes the response back to the owning master.
- Terminates hung transactions with an error completion after a programmable timeout.

---
 rtl/alion_mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_alion_mem_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alion_mem_arbiter.sv
// Two-master round-robin arbiter for the alion native memory port.
// It latches the granted request, routes the completion back to its owner and ends hung transactions with an error after TIMEOUT cycles.
module alion_mem_arbiter #(
   parameter int unsigned TIMEOUT   = 255,
   parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic        m0_ready,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic        m1_ready,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        mem_valid,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        busy,
   output logic        owner
);

   localparam int unsigned CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TLIM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

   state_e        state_q, state_d;
   logic          last_q, last_d;
   logic          owner_q, owner_d;
   logic          instr_q, instr_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [CW-1:0] tcnt_q, tcnt_d;

   logic          tmo_s, done_s, err_s, req_s, grant_s;

   // Arbitration, completion detection and next-state for all latched fields.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      instr_d = instr_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      tcnt_d  = tcnt_q;
      req_s   = 1'b0;
      grant_s = owner_q;
      tmo_s   = 1'b0;
      done_s  = 1'b0;
      err_s   = 1'b0;

      if (state_q == S_BUSY) begin
         tmo_s  = (TIMEOUT != 0) && (tcnt_q == TLIM);
         // A slave ready in the timeout cycle still counts as a clean completion.
         done_s = mem_ready | tmo_s;
         err_s  = ~mem_ready & tmo_s;
      end else begin
         tmo_s  = 1'b0;
      end

      case (state_q)
         S_IDLE: begin
            if (m0_valid | m1_valid) begin
               req_s   = 1'b1;
               grant_s = (m0_valid & m1_valid) ? ~last_q : m1_valid;
            end else begin
               req_s   = 1'b0;
            end
         end
         S_BUSY: begin
            if (done_s) begin
               last_d = owner_q;
               // The completing owner's valid is stale here, so only the other master may be granted.
               if (owner_q ? m0_valid : m1_valid) begin
                  req_s   = 1'b1;
                  grant_s = ~owner_q;
               end else begin
                  state_d = S_IDLE;
               end
            end else if ((TIMEOUT != 0) && (tcnt_q != TLIM)) begin
               tcnt_d = tcnt_q + CW'(1'b1);
            end else begin
               tcnt_d = tcnt_q;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (req_s) begin
         state_d = S_BUSY;
         owner_d = grant_s;
         tcnt_d  = '0;
         instr_d = grant_s ? m1_instr : m0_instr;
         addr_d  = grant_s ? m1_addr  : m0_addr;
         wdata_d = grant_s ? m1_wdata : m0_wdata;
         wstrb_d = grant_s ? m1_wstrb : m0_wstrb;
      end else begin
         owner_d = owner_d;
      end
   end

   // State and latched-request registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         instr_q <= 1'b0;
         addr_q  <= 32'h0000_0000;
         wdata_q <= 32'h0000_0000;
         wstrb_q <= 4'h0;
         tcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         instr_q <= instr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         tcnt_q  <= tcnt_d;
      end
   end

   assign mem_valid = (state_q == S_BUSY);
   assign busy      = (state_q == S_BUSY);
   assign owner     = owner_q;
   assign mem_instr = instr_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_wstrb = wstrb_q;

   assign m0_ready  = done_s & ~owner_q;
   assign m1_ready  = done_s &  owner_q;
   assign m0_err    = m0_ready & err_s;
   assign m1_err    = m1_ready & err_s;
   assign m0_rdata  = m0_ready ? (err_s ? ERR_RDATA : mem_rdata) : 32'h0000_0000;
   assign m1_rdata  = m1_ready ? (err_s ? ERR_RDATA : mem_rdata) : 32'h0000_0000;

endmodule

// File: tb/tb_alion_mem_arbiter.sv
// Directed bench for alion_mem_arbiter with TIMEOUT=4 and a distinctive ERR_RDATA.
module tb_alion_mem_arbiter;

   localparam logic [31:0] ERRV = 32'hEEEE_0001;

   logic        clock = 1'b0;
   logic        reset;
   logic        m0_valid, m0_instr, m1_valid, m1_instr;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic [3:0]  m0_wstrb, m1_wstrb;
   logic        m0_ready, m0_err, m1_ready, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        mem_valid, mem_instr, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_wstrb;
   logic        busy, owner;

   int n_checks = 0;
   int n_fail   = 0;

   alion_mem_arbiter #(.TIMEOUT(4), .ERR_RDATA(ERRV)) dut (
      .clock(clock), .reset(reset),
      .m0_valid(m0_valid), .m0_instr(m0_instr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_instr(m1_instr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   initial begin
      reset = 1'b1;
      m0_valid = 1'b0; m0_instr = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0; m0_wstrb = 4'h0;
      m1_valid = 1'b0; m1_instr = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0; m1_wstrb = 4'h0;
      mem_ready = 1'b0; mem_rdata = 32'h0;
      #2;
      chk("rst_mem_valid", {31'h0, mem_valid}, 32'h0);
      chk("rst_busy",      {31'h0, busy},      32'h0);
      chk("rst_owner",     {31'h0, owner},     32'h0);
      chk("rst_mem_addr",  mem_addr,           32'h0);
      chk("rst_m0_ready",  {31'h0, m0_ready},  32'h0);
      #1 reset = 1'b0;

      // Contention after reset: m0 first, then m1 back-to-back.
      m0_valid = 1'b1; m0_addr = 32'h0000_0000;
      m1_valid = 1'b1; m1_addr = 32'h0000_2000;
      #1 chk("con_no_grant_yet", {31'h0, mem_valid}, 32'h0);
      tick();
      chk("con_valid0", {31'h0, mem_valid}, 32'h1);
      chk("con_owner0", {31'h0, owner},     32'h0);
      chk("con_addr0",  mem_addr,           32'h0000_0000);
      mem_ready = 1'b1; mem_rdata = 32'h0000_0011;
      #1;
      chk("con_m0_ready", {31'h0, m0_ready}, 32'h1);
      chk("con_m0_rdata", m0_rdata,          32'h0000_0011);
      chk("con_m1_ready", {31'h0, m1_ready}, 32'h0);
      chk("con_m1_rdata", m1_rdata,          32'h0);
      tick();
      m0_valid = 1'b0; mem_ready = 1'b0;
      #1;
      chk("con_valid_cont", {31'h0, mem_valid}, 32'h1);
      chk("con_owner1",     {31'h0, owner},     32'h1);
      chk("con_addr1",      mem_addr,           32'h0000_2000);
      mem_ready = 1'b1; mem_rdata = 32'h0000_0022;
      #1;
      chk("con_m1_ready2", {31'h0, m1_ready}, 32'h1);
      chk("con_m1_rdata2", m1_rdata,          32'h0000_0022);
      chk("con_m0_ready2", {31'h0, m0_ready}, 32'h0);
      tick();
      m1_valid = 1'b0; mem_ready = 1'b0;
      #1;
      chk("con_idle_busy",  {31'h0, busy},      32'h0);
      chk("con_idle_valid", {31'h0, mem_valid}, 32'h0);
      chk("con_addr_hold",  mem_addr,           32'h0000_2000);

      // Second contention with last=1 grants m0 again.
      m0_valid = 1'b1; m0_addr = 32'h0000_0040;
      m1_valid = 1'b1; m1_addr = 32'h0000_2040;
      tick();
      chk("con2_owner", {31'h0, owner}, 32'h0);
      chk("con2_addr",  mem_addr,       32'h0000_0040);
      mem_ready = 1'b1; mem_rdata = 32'h0000_0033;
      tick();
      m0_valid = 1'b0; mem_rdata = 32'h0000_0044;
      #1;
      chk("con2_owner_m1",  {31'h0, owner},    32'h1);
      chk("con2_m1_rdata",  m1_rdata,          32'h0000_0044);
      tick();
      m1_valid = 1'b0; mem_ready = 1'b0;
      #1 chk("con2_idle", {31'h0, busy}, 32'h0);

      // Single read; slave answers on the 2nd mem_valid cycle.
      m0_valid = 1'b1; m0_addr = 32'h0000_0100; m0_wstrb = 4'h0;
      tick();
      chk("rd_valid1",    {31'h0, mem_valid}, 32'h1);
      chk("rd_addr",      mem_addr,           32'h0000_0100);
      chk("rd_no_ready1", {31'h0, m0_ready},  32'h0);
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("rd_ready", {31'h0, m0_ready}, 32'h1);
      chk("rd_rdata", m0_rdata,          32'hDEAD_BEEF);
      chk("rd_err",   {31'h0, m0_err},   32'h0);
      chk("rd_m1",    {31'h0, m1_ready}, 32'h0);
      tick();
      m0_valid = 1'b0; mem_ready = 1'b0;
      #1;
      chk("rd_idle",       {31'h0, mem_valid}, 32'h0);
      chk("rd_ready_low",  {31'h0, m0_ready},  32'h0);
      chk("rd_rdata_zero", m0_rdata,           32'h0);

      // m1 write passthrough held stable while m1 changes its inputs.
      m1_valid = 1'b1; m1_addr = 32'h0000_2004; m1_wdata = 32'h1234_5678;
      m1_wstrb = 4'b0011; m1_instr = 1'b0;
      tick();
      m1_addr = 32'h0000_FFFF; m1_wdata = 32'h0; m1_wstrb = 4'hF; m1_instr = 1'b1;
      tick();
      chk("wr_addr",  mem_addr,            32'h0000_2004);
      chk("wr_wdata", mem_wdata,           32'h1234_5678);
      chk("wr_wstrb", {28'h0, mem_wstrb},  32'h3);
      chk("wr_instr", {31'h0, mem_instr},  32'h0);
      mem_ready = 1'b1; mem_rdata = 32'h0;
      #1 chk("wr_ready", {31'h0, m1_ready}, 32'h1);
      tick();
      m1_valid = 1'b0; mem_ready = 1'b0;

      // Timeout: slave never answers; m0 completes with error on BUSY cycle 4.
      m0_valid = 1'b1; m0_addr = 32'h0000_0300;
      tick();
      chk("to_c1_valid", {31'h0, mem_valid}, 32'h1);
      tick();
      tick();
      chk("to_c3_valid", {31'h0, mem_valid}, 32'h1);
      chk("to_c3_ready", {31'h0, m0_ready},  32'h0);
      tick();
      chk("to_c4_valid", {31'h0, mem_valid}, 32'h1);
      chk("to_c4_ready", {31'h0, m0_ready},  32'h1);
      chk("to_c4_err",   {31'h0, m0_err},    32'h1);
      chk("to_c4_rdata", m0_rdata,           ERRV);
      tick();
      m0_valid = 1'b0;
      #1 chk("to_idle", {31'h0, mem_valid}, 32'h0);
      mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
      #1;
      chk("to_late_m0", {31'h0, m0_ready}, 32'h0);
      chk("to_late_m1", {31'h0, m1_ready}, 32'h0);
      tick();
      mem_ready = 1'b0;
      #1 chk("to_late_busy", {31'h0, busy}, 32'h0);

      // Timeout race: ready in the 4th BUSY cycle wins.
      m0_valid = 1'b1;
      tick();
      tick();
      tick();
      tick();
      mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
      #1;
      chk("race_ready", {31'h0, m0_ready}, 32'h1);
      chk("race_err",   {31'h0, m0_err},   32'h0);
      chk("race_rdata", m0_rdata,          32'hCAFE_0001);
      tick();
      m0_valid = 1'b0; mem_ready = 1'b0;

      // Reset mid-transaction for m1 (last=0 now, so without reset m1 would win).
      m1_valid = 1'b1; m1_addr = 32'h0000_2100;
      tick();
      chk("rm_owner", {31'h0, owner}, 32'h1);
      mem_ready = 1'b1;
      #1 chk("rm_pre_ready", {31'h0, m1_ready}, 32'h1);
      reset = 1'b1;
      #1;
      chk("rm_valid", {31'h0, mem_valid}, 32'h0);
      chk("rm_busy",  {31'h0, busy},      32'h0);
      chk("rm_ready", {31'h0, m1_ready},  32'h0);
      mem_ready = 1'b0; m1_valid = 1'b0;
      #1 reset = 1'b0;
      m0_valid = 1'b1; m0_addr = 32'h0000_0500;
      m1_valid = 1'b1; m1_addr = 32'h0000_2500;
      tick();
      chk("rm_regrant_owner", {31'h0, owner}, 32'h0);
      chk("rm_regrant_addr",  mem_addr,       32'h0000_0500);
      m0_valid = 1'b0; m1_valid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
